// File: rtl/fpu_add_arbiter.sv
// rtl/fpu_add_arbiter.sv - round-robin arbiter sharing one single-precision adder among NUM_REQ requesters
// One operation is in flight at a time; its result is returned only to the lane that issued it.
module fpu_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [31:0]           rsp_z,
   output logic [31:0]           add_a,
   output logic [31:0]           add_b,
   output logic                  add_a_stb,
   output logic                  add_b_stb,
   input  logic                  add_a_ack,
   input  logic                  add_b_ack,
   input  logic [31:0]           add_z,
   input  logic                  add_z_stb,
   output logic                  add_z_ack,
   output logic                  busy,
   output logic [ID_W-1:0]       grant_id
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SEND    = 2'd1;
   localparam logic [1:0] S_WAIT_Z  = 2'd2;
   localparam logic [1:0] S_RESPOND = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        z_q, z_d;
   logic               a_done_q, a_done_d;
   logic               b_done_q, b_done_d;

   logic               win_found;
   logic [ID_W-1:0]    win_idx;
   logic [NUM_REQ-1:0] win_onehot;
   logic [NUM_REQ-1:0] grant_onehot;
   logic               accept;
   logic               a_fin;
   logic               b_fin;
   logic               rsp_take;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return ID_W'(sum);
   endfunction

   // First requesting lane at or above the pointer, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_valid[wrap_add(rr_q, i)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(rr_q, i);
         end
      end
   end

   assign win_onehot   = NUM_REQ'(1) << win_idx;
   assign grant_onehot = NUM_REQ'(1) << grant_q;

   assign accept    = (state_q == S_IDLE) && win_found;
   assign req_ready = accept ? win_onehot : '0;

   assign add_a_stb = (state_q == S_SEND) && !a_done_q;
   assign add_b_stb = (state_q == S_SEND) && !b_done_q;
   assign a_fin     = a_done_q || (add_a_stb && add_a_ack);
   assign b_fin     = b_done_q || (add_b_stb && add_b_ack);
   assign add_a     = a_q;
   assign add_b     = b_q;

   assign add_z_ack = (state_q == S_WAIT_Z) && add_z_stb;

   assign rsp_valid = (state_q == S_RESPOND) ? grant_onehot : '0;
   assign rsp_take  = (state_q == S_RESPOND) && rsp_ready[grant_q];
   assign rsp_z     = z_q;

   assign busy      = (state_q != S_IDLE);
   assign grant_id  = grant_q;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      grant_d  = grant_q;
      a_d      = a_q;
      b_d      = b_q;
      z_d      = z_q;
      a_done_d = a_done_q;
      b_done_d = b_done_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d      = req_a[32*win_idx +: 32];
               b_d      = req_b[32*win_idx +: 32];
               grant_d  = win_idx;
               a_done_d = 1'b0;
               b_done_d = 1'b0;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            // Each strobe retires independently; move on only once both have been taken.
            a_done_d = a_fin;
            b_done_d = b_fin;
            if (a_fin && b_fin) state_d = S_WAIT_Z;
         end
         S_WAIT_Z: begin
            if (add_z_stb) begin
               z_d     = add_z;
               state_d = S_RESPOND;
            end
         end
         S_RESPOND: begin
            if (rsp_take) begin
               rr_d    = wrap_add(grant_q, 1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         grant_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         z_q      <= '0;
         a_done_q <= 1'b0;
         b_done_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         grant_q  <= grant_d;
         a_q      <= a_d;
         b_q      <= b_d;
         z_q      <= z_d;
         a_done_q <= a_done_d;
         b_done_q <= b_done_d;
      end
   end
endmodule

// File: doc/fpu_add_arbiter.md
# fpu_add_arbiter

Shares one single-precision floating-point adder (strobe/ack handshake on both operands and on the result) between `NUM_REQ` requesters. The block sits between client datapaths and the adder. It grants the adder round-robin, one operation at a time, and sequences the adder's operand and result handshakes. It returns each result only to the requester that issued the operation.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `ID_W`, 2, grant index width, equal to clog2(`NUM_REQ`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_a`, `req_b`  in  NUM_REQ*32  operand A and operand B; requester i uses bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot accept.
- `rsp_valid`  out  NUM_REQ  one-hot result valid.
- `rsp_ready`  in  NUM_REQ  per-requester result accept.
- `rsp_z`  out  32  result, broadcast to all requesters.
- `add_a`, `add_b`  out  32  operands to the adder.
- `add_a_stb`, `add_b_stb`  out  1  operand strobes.
- `add_a_ack`, `add_b_ack`  in  1  operand acks from the adder.
- `add_z`  in  32  adder result.
- `add_z_stb`  in  1  adder result strobe.
- `add_z_ack`  out  1  result ack to the adder.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  ID_W  index of the current or last grant.

## Operation
- FSM states: IDLE, SEND, WAIT_Z, RESPOND.
- **IDLE**
  - The round-robin winner w is the first i with `req_valid[i]` set, searching upward from pointer `rr` and wrapping modulo `NUM_REQ`.
  - `req_ready[w]` is driven combinationally: it is high only in IDLE and only for w.
  - On `req_valid[w]`&`req_ready[w]` the block latches `req_a[w]`, `req_b[w]` and w into `grant_id`, then moves to SEND.
  - With no request pending it stays in IDLE.
- **SEND**
  - `add_a_stb` and `add_b_stb` are high. Each one drops in the cycle after its ack is sampled high; sticky done flags track this.
  - The two acks may arrive in the same cycle or in different cycles.
  - Once both are done, the block moves to WAIT_Z.
  - `add_a` and `add_b` hold the latched operands for the whole of SEND.
- **WAIT_Z**
  - `add_z_ack` = `add_z_stb` (combinational).
  - On `add_z_stb`, the block captures `add_z` into the result register and moves to RESPOND.
- **RESPOND**
  - `rsp_valid[grant_id]` is high and `rsp_z` = the result register.
  - On `rsp_ready[grant_id]`:
    - `rr` ← (`grant_id`+1) mod `NUM_REQ`;
    - the block returns to IDLE.
  - `rsp_valid` stays high until accepted.
  - `rsp_ready` on any non-granted lane is ignored.
- Stray inputs:
  - `add_*_ack` outside SEND is ignored.
  - `add_z_stb` outside WAIT_Z is ignored, and `add_z_ack` stays low.
- Request lanes:
  - A requester may drop `req_valid` before it is granted. No grant is then issued to it.
  - Operands are sampled only in the accept cycle.
- Fairness: a requester with a continuous request waits at most `NUM_REQ`-1 operations before it is granted.

## Timing
- Reset: when `rst`=0 at a clock edge, the following apply at the next edge.
  - State is IDLE and `rr` is 0.
  - These outputs are 0: all strobes, `add_z_ack`, `rsp_valid`, `busy`, `grant_id`, `rsp_z`, `add_a`, `add_b`. `req_ready` follows from these states and is combinational.
  - Reset mid-operation abandons the operation silently. The adder shares `rst` and is reset too.
- With the accept in cycle T:
  - strobes are high from T+1;
  - WAIT_Z begins no earlier than T+2;
  - a result strobe in cycle R gives `rsp_valid` from R+1.
- Cycles with no added bubble:
  - RESPOND → IDLE costs one cycle;
  - the next accept is possible in the cycle after the response handshake.
- Throughput: at most one operation in flight. Minimum occupancy is 4 + adder latency.

## Test plan
- **Single requester**
  - Stimulus: req 0 with A=0x433E95C3 (190.585), B=0x40E80000 (7.25).
  - Response: the adder sees exactly these operands. `rsp_valid[0]` goes high with `rsp_z`=0x4345D5C3 (197.835). `busy` falls after `rsp_ready[0]`.
- **Round-robin**
  - Stimulus: all 4 requesters assert continuously from reset, each with distinct operands (req i: A=i+1.0, B=1.0).
  - Response: grant order is 0,1,2,3,0. Each `rsp_z` matches its own lane (e.g. lane 1: 2.0+1.0 → 0x40400000).
- **Split acks**
  - Stimulus: the adder model acks B 3 cycles before A.
  - Response: `add_b_stb` drops the cycle after its ack and `add_a_stb` holds until its own ack. Result 0x40000000 + 0x40400000 → 0x40A00000.
- **Response backpressure**
  - Stimulus: hold `rsp_ready[2]`=0 for 10 cycles while lanes 0 and 1 request.
  - Response: `rsp_valid[2]` and `rsp_z` are stable and no new `req_ready` is issued. Lane 3's `rsp_ready`=1 has no effect.
- **Reset mid-operation**
  - Stimulus: drive `rst`=0 for one cycle while in WAIT_Z.
  - Response: the next cycle is IDLE with all outputs zero, and a stray `add_z_stb` gets no ack. The next grant goes to lane 0 when lanes 0 and 2 request.
